interp2_smoother: RTL

//   2x upsampling interpolator: the expansion counterpart of the ce-gated [1,2,1]/4 decimating smoother.
//   For each accepted sample x[n] it emits y[2n]=x[n], then y[2n+1]=(x[n]+x[n+1])/2.

---
 rtl/interp2_smoother_pkg.sv | 7 +
 rtl/interp2_smoother_if.sv | 24 ++
 rtl/interp2_smoother_midpoint.sv | 23 ++
 rtl/interp2_smoother.sv | 109 ++++++++++
 4 files changed

// File: rtl/interp2_smoother_pkg.sv
// Shared types and defaults for the 2x interpolating smoother.
// INTERP_ROUND_EN (see interp2_midpoint) selects rounding of the odd outputs.
package interp_pkg;
    localparam int INTERP_W_DEFAULT = 8;

    typedef enum logic [1:0] {IDLE, EVEN, ODD} interp_state_t;
endpackage

// File: rtl/interp2_smoother_if.sv
// Sample-stream interface: valid/ready input side, valid/ready output side, shared clock enable.
interface interp2_smoother_if
    import interp_pkg::*;
#(
    parameter int W = INTERP_W_DEFAULT
) ();
    logic                ce;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] din;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] dout;

    modport master (
        output ce, in_valid, din, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  ce, in_valid, din, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/interp2_smoother_midpoint.sv
// Combinational midpoint of two signed samples; INTERP_ROUND_EN rounds half toward +inf,
// otherwise the halving truncates toward -inf. The W+1 bit sum cannot overflow.
module interp2_midpoint #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] mid
);
    logic signed [W:0] sum;

    assign sum = {a[W-1], a} + {b[W-1], b};

`ifdef INTERP_ROUND_EN
    logic signed [W:0] sum_rnd;

    // Max sum+1 is 2^W-1, still representable in W+1 signed bits.
    assign sum_rnd = sum + $signed((W+1)'(1));
    assign mid     = W'(sum_rnd >>> 1);
`else
    assign mid = W'(sum >>> 1);
`endif
endmodule

// File: rtl/interp2_smoother.sv
// 2x upsampling interpolator: emits x[n], then the midpoint of x[n] and x[n+1].
// Odd-output rounding is selected by INTERP_ROUND_EN inside interp2_midpoint.
module interp2_smoother
    import interp_pkg::*;
#(
    parameter int W = INTERP_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    interp2_smoother_if.slave  bus
);
    interp_state_t       state_reg, state_next;
    logic signed [W-1:0] prev_reg, prev_next;
    logic signed [W-1:0] cur_reg, cur_next;
    logic                cur_full_reg, cur_full_next;
    logic                out_valid_reg, out_valid_next;
    logic signed [W-1:0] dout_reg, dout_next;
    logic signed [W-1:0] mid_next;
    logic                in_ready_raw;
    logic                in_acc;
    logic                out_acc;

    assign in_ready_raw  = (state_reg == IDLE) ? 1'b1 : !cur_full_reg;
    assign bus.in_ready  = rst_n & bus.ce & in_ready_raw;
    assign bus.out_valid = bus.ce & out_valid_reg;
    assign bus.dout      = dout_reg;

    assign in_acc  = bus.ce & bus.in_valid & bus.in_ready;
    assign out_acc = bus.ce & bus.out_valid & bus.out_ready;

    always_comb begin
        state_next    = state_reg;
        prev_next     = prev_reg;
        cur_next      = cur_reg;
        cur_full_next = cur_full_reg;
        case (state_reg)
            IDLE: begin
                if (in_acc) begin
                    prev_next  = bus.din;
                    state_next = EVEN;
                end
            end
            EVEN: begin
                if (in_acc) begin
                    cur_next      = bus.din;
                    cur_full_next = 1'b1;
                end
                if (out_acc) state_next = ODD;
            end
            ODD: begin
                // in_acc needs cur_full=0 while out_acc needs cur_full=1, so they never coincide.
                if (in_acc) begin
                    cur_next      = bus.din;
                    cur_full_next = 1'b1;
                end
                if (out_acc) begin
                    prev_next     = cur_reg;
                    cur_full_next = 1'b0;
                    state_next    = EVEN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    interp2_midpoint #(.W(W)) u_mid (
        .a   (prev_next),
        .b   (cur_next),
        .mid (mid_next)
    );

    // Outputs are precomputed from the next-state values so they leave a register.
    always_comb begin
        out_valid_next = 1'b0;
        dout_next      = '0;
        case (state_next)
            EVEN: begin
                out_valid_next = 1'b1;
                dout_next      = prev_next;
            end
            ODD: begin
                out_valid_next = cur_full_next;
                dout_next      = mid_next;
            end
            default: begin
                out_valid_next = 1'b0;
                dout_next      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            prev_reg      <= '0;
            cur_reg       <= '0;
            cur_full_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            prev_reg      <= prev_next;
            cur_reg       <= cur_next;
            cur_full_reg  <= cur_full_next;
            out_valid_reg <= out_valid_next;
            dout_reg      <= dout_next;
        end
    end
endmodule
